// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART Tx/Rx data units.
//   - rx_state_t   : receive FSM state encoding (IDLE..STOP)
//   - DATA_LENGTH_DEF : default number of data bits per frame
//   - FRAME_BITS   : start + data + parity + stop, shared with the Tx side
//   - PARITY_EVEN / PARITY_ODD : encoding of the Parity mode input
//   - maj3()       : 2-of-3 majority helper used by the optional voting sampler
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int   DATA_LENGTH_DEF = 9;
  localparam int   FRAME_BITS      = 12;
  localparam logic PARITY_EVEN     = 1'b0;
  localparam logic PARITY_ODD      = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_sync_edge.sv
// -----------------------------------------------------------------------------
// rx_sync_edge
// Two-flop synchroniser for the asynchronous serial line plus a falling-edge
// detector on the synchronised value.
// Ports:
//   Clock   in   system clock
//   Reset   in   asynchronous active-low reset; all flops reset to 1 (idle
//                line level) so releasing reset never looks like a start edge
//   i_rx    in   raw serial line
//   o_rxs   out  synchronised line (RxS)
//   o_fall  out  RxP=1 and RxS=0, i.e. a 1->0 transition of the line
// -----------------------------------------------------------------------------
module rx_sync_edge (
  input  logic Clock,
  input  logic Reset,
  input  logic i_rx,
  output logic o_rxs,
  output logic o_fall
);

  logic r_meta;
  logic r_rxs;
  logic r_rxp;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_meta <= 1'b1;
      r_rxs  <= 1'b1;
      r_rxp  <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_rxs  <= r_meta;
      r_rxp  <= r_rxs;
    end
  end

  assign o_rxs  = r_rxs;
  assign o_fall = r_rxp & ~r_rxs;

endmodule

// File: rtl/rx_data_unit.sv
// -----------------------------------------------------------------------------
// rx_data_unit
// Serial receive stage. Frame on the line, LSB first:
//   idle 1, start 0, D0..D(DataLength-1), parity, stop 1.
// The line is oversampled with SampleTick (Oversample ticks per bit). The
// start bit is validated at its middle, then every bit is sampled at mid-bit.
//
// Output strobe: DataValid is a one-cycle pulse; Data, ParityError and
// FramingError update on the same cycle and hold until the next pulse. There
// is no back-pressure: the consumer must take the word on the pulse.
//
// Optional build macro RX_MAJORITY_VOTE_EN: each bit is the 2-of-3 majority
// of samples at mid-1, mid, mid+1; the decision is taken at mid+1.
//
// Ports:
//   Clock        in   system clock
//   Reset        in   asynchronous active-low reset
//   SampleTick   in   oversampling enable, one Clock wide
//   Rx           in   asynchronous serial line, idle high
//   Parity       in   0 = even, 1 = odd
//   Data         out  last received word
//   DataValid    out  one-cycle strobe when outputs update
//   ParityError  out  parity mismatch on the last frame
//   FramingError out  stop bit sampled 0 on the last frame
//   Busy         out  FSM not in IDLE
//   DbgState     out  current FSM state (observation only)
// -----------------------------------------------------------------------------
module rx_data_unit
  import uart_pkg::*;
#(
  parameter int DataLength = DATA_LENGTH_DEF,
  parameter int Oversample = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  SampleTick,
  input  logic                  Rx,
  input  logic                  Parity,
  output logic [DataLength-1:0] Data,
  output logic                  DataValid,
  output logic                  ParityError,
  output logic                  FramingError,
  output logic                  Busy,
  output rx_state_t             DbgState
);

  localparam int TW = $clog2(Oversample);
  localparam int BW = $clog2(DataLength);

  localparam logic [TW-1:0] MID_START = TW'(Oversample / 2 - 1);
  localparam logic [TW-1:0] MID_BIT   = TW'(Oversample - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DataLength - 1);

`ifdef RX_MAJORITY_VOTE_EN
  // The start decision happens one tick after the start mid-point, so the
  // counter restarts at 1 to keep later mid-points on TickCnt = Oversample-1.
  localparam logic [TW-1:0] START_RELOAD = TW'(1);
`else
  localparam logic [TW-1:0] START_RELOAD = TW'(0);
`endif

  rx_state_t             r_state;
  logic [TW-1:0]         r_tick_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [DataLength-1:0] r_shift;
  logic                  r_rx_par;

  logic                  w_rxs;
  logic                  w_fall;
  logic [TW-1:0]         w_mid;
  logic                  w_decide;
  logic                  w_bit;

  rx_sync_edge u_sync (
    .Clock  (Clock),
    .Reset  (Reset),
    .i_rx   (Rx),
    .o_rxs  (w_rxs),
    .o_fall (w_fall)
  );

  assign w_mid = (r_state == ST_START) ? MID_START : MID_BIT;

`ifdef RX_MAJORITY_VOTE_EN
  // r_vote holds the samples taken at mid-1 (bit 1) and mid (bit 0);
  // r_armed marks that the next tick is mid+1, where the vote is resolved.
  // Using a flag avoids confusing mid+1 (which wraps to 0 in DATA) with the
  // counter value at the start of a bit.
  logic [1:0] r_vote;
  logic       r_armed;

  assign w_decide = SampleTick & r_armed;
  assign w_bit    = maj3(r_vote[1], r_vote[0], w_rxs);
`else
  assign w_decide = SampleTick & (r_tick_cnt == w_mid);
  assign w_bit    = w_rxs;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state      <= ST_IDLE;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_rx_par     <= 1'b0;
      Data         <= '0;
      DataValid    <= 1'b0;
      ParityError  <= 1'b0;
      FramingError <= 1'b0;
`ifdef RX_MAJORITY_VOTE_EN
      r_vote       <= 2'b11;
      r_armed      <= 1'b0;
`endif
    end else begin
      DataValid <= 1'b0;

      // Free-running oversample counter while a frame is in progress; the
      // state actions below override it where a restart is needed.
      if (r_state != ST_IDLE && SampleTick) begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end

`ifdef RX_MAJORITY_VOTE_EN
      if (r_state != ST_IDLE && SampleTick) begin
        if (r_armed) begin
          r_armed <= 1'b0;
        end else if (r_tick_cnt == (w_mid - 1'b1)) begin
          r_vote <= {r_vote[0], w_rxs};
        end else if (r_tick_cnt == w_mid) begin
          r_vote  <= {r_vote[0], w_rxs};
          r_armed <= 1'b1;
        end
      end
`endif

      case (r_state)
        ST_IDLE: begin
          // Edge detection does not wait for SampleTick.
          if (w_fall) begin
            r_tick_cnt <= '0;
            r_state    <= ST_START;
          end
        end

        ST_START: begin
          if (w_decide) begin
            if (!w_bit) begin
              r_tick_cnt <= START_RELOAD;
              r_bit_cnt  <= '0;
              r_state    <= ST_DATA;
            end else begin
              // Glitch shorter than half a bit: false start.
              r_state <= ST_IDLE;
            end
          end
        end

        ST_DATA: begin
          if (w_decide) begin
            // Shift in from the top so D0 ends at bit 0 after the last bit.
            r_shift <= {w_bit, r_shift[DataLength-1:1]};
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= ST_PARITY;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

        ST_PARITY: begin
          if (w_decide) begin
            r_rx_par <= w_bit;
            r_state  <= ST_STOP;
          end
        end

        ST_STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is caught.
          if (w_decide) begin
            Data         <= r_shift;
            ParityError  <= Parity ^ (^r_shift) ^ r_rx_par;
            FramingError <= ~w_bit;
            DataValid    <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Busy     = (r_state != ST_IDLE);
  assign DbgState = r_state;

endmodule

// File: tb/tb_rx_data_unit.sv
// -----------------------------------------------------------------------------
// tb_rx_data_unit
// Directed bench for rx_data_unit: drives complete serial frames on Rx,
// compares every DataValid word against an expected queue, and checks the
// counts/timing of DataValid pulses and the Busy/flag outputs.
// -----------------------------------------------------------------------------
module tb_rx_data_unit;
  import uart_pkg::*;

  localparam int DL       = 9;
  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = OS * TICK_DIV;

  // ---------------- clock / reset / tick ----------------
  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic tick   = 1'b0;
  logic rx     = 1'b1;
  logic parity = 1'b0;

  logic [DL-1:0] data;
  logic          dv;
  logic          perr;
  logic          ferr;
  logic          busy;
  rx_state_t     dbg_state;

  always #5 clk = ~clk;

  int tick_div = 0;
  always @(negedge clk) begin
    tick_div = (tick_div + 1) % TICK_DIV;
    tick     = (tick_div == 0);
  end

  int cycle = 0;
  always @(posedge clk) cycle = cycle + 1;

  rx_data_unit #(.DataLength(DL), .Oversample(OS)) dut (
    .Clock        (clk),
    .Reset        (rst_n),
    .SampleTick   (tick),
    .Rx           (rx),
    .Parity       (parity),
    .Data         (data),
    .DataValid    (dv),
    .ParityError  (perr),
    .FramingError (ferr),
    .Busy         (busy),
    .DbgState     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [DL+1:0] exp_q[$];
  int            dv_time[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            dv_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dv === 1'b1) begin
      dv_count = dv_count + 1;
      dv_time.push_back(cycle);
      if (exp_q.size() == 0) begin
        check("dv_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        check("dv_word", 32'({ferr, perr, data}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!tick);
    end
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [DL-1:0] d, input logic par_bit,
                            input logic stop_bit, input int nbits);
    logic [FRAME_BITS-1:0] f;
    f = {stop_bit, par_bit, d, 1'b0};
    for (int i = 0; i < nbits; i++) drive_bit(f[i]);
  endtask

  task automatic expect_word(input logic [DL-1:0] d, input logic pe, input logic fe);
    exp_q.push_back({fe, pe, d});
  endtask

  // ---------------- stimulus ----------------
  int base;
  int n_t;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  32'(data), 32'd0);
    check("rst_dv",    32'(dv),   32'd0);
    check("rst_perr",  32'(perr), 32'd0);
    check("rst_ferr",  32'(ferr), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    wait_ticks(OS);

    // 1: even parity, 9'h1A5 has 5 ones -> parity bit 1
    parity = PARITY_EVEN;
    base = dv_count;
    expect_word(9'h1A5, 1'b0, 1'b0);
    send_frame(9'h1A5, 1'b1, 1'b1, FRAME_BITS);
    wait_ticks(4);
    check("t1_dv_count", 32'(dv_count - base), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);

    // 2a: odd parity, correct parity bit 0
    parity = PARITY_ODD;
    base = dv_count;
    expect_word(9'h1A5, 1'b0, 1'b0);
    send_frame(9'h1A5, 1'b0, 1'b1, FRAME_BITS);
    wait_ticks(4);
    check("t2a_dv_count", 32'(dv_count - base), 32'd1);

    // 2b: odd parity, flipped parity bit -> error, data intact
    base = dv_count;
    expect_word(9'h1A5, 1'b1, 1'b0);
    send_frame(9'h1A5, 1'b1, 1'b1, FRAME_BITS);
    wait_ticks(OS);
    check("t2b_dv_count", 32'(dv_count - base), 32'd1);
    check("t2b_perr_hold", 32'(perr), 32'd1);
    check("t2b_data_hold", 32'(data), 32'h1A5);

    // 3: glitch of 4 ticks on idle line
    parity = PARITY_EVEN;
    base = dv_count;
    rx = 1'b0;
    wait_ticks(2);
    check("t3_busy_on", 32'(busy), 32'd1);
    wait_ticks(2);
    rx = 1'b1;
    wait_ticks(OS);
    check("t3_busy_off", 32'(busy), 32'd0);
    check("t3_dv_count", 32'(dv_count - base), 32'd0);

    // 4: framing error, 9'h0F0 (4 ones, parity 0), stop 0 then break
    base = dv_count;
    expect_word(9'h0F0, 1'b0, 1'b1);
    send_frame(9'h0F0, 1'b0, 1'b0, FRAME_BITS);
    wait_ticks(3 * OS);
    check("t4_dv_count", 32'(dv_count - base), 32'd1);
    check("t4_ferr", 32'(ferr), 32'd1);
    check("t4_busy_break", 32'(busy), 32'd0);
    rx = 1'b1;
    wait_ticks(OS);
    check("t4_no_second_dv", 32'(dv_count - base), 32'd1);
    expect_word(9'h1A5, 1'b0, 1'b0);
    send_frame(9'h1A5, 1'b1, 1'b1, FRAME_BITS);
    wait_ticks(4);
    check("t4_recover_count", 32'(dv_count - base), 32'd2);
    check("t4_ferr_clear", 32'(ferr), 32'd0);

    // 5: back-to-back frames, no idle gap
    base = dv_count;
    expect_word(9'h000, 1'b0, 1'b0);
    expect_word(9'h1FF, 1'b0, 1'b0);
    send_frame(9'h000, 1'b0, 1'b1, FRAME_BITS);
    send_frame(9'h1FF, 1'b1, 1'b1, FRAME_BITS);
    wait_ticks(4);
    check("t5_dv_count", 32'(dv_count - base), 32'd2);
    n_t = dv_time.size();
    if (n_t >= 2) begin
      check("t5_spacing", 32'(dv_time[n_t-1] - dv_time[n_t-2]), 32'(FRAME_BITS * BIT_CLKS));
    end else begin
      check("t5_spacing_pulses", 32'(n_t), 32'd2);
    end

    // 6: reset during D4 of 9'h0FF
    base = dv_count;
    send_frame(9'h0FF, 1'b0, 1'b1, 5);
    rx = 1'b1;
    wait_ticks(OS / 2);
    check("t6_busy_mid", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #2;
    check("t6_rst_data", 32'(data), 32'd0);
    check("t6_rst_perr", 32'(perr), 32'd0);
    check("t6_rst_ferr", 32'(ferr), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ticks(2 * OS);
    check("t6_no_dv", 32'(dv_count - base), 32'd0);
    check("t6_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    expect_word(9'h055, 1'b0, 1'b0);
    send_frame(9'h055, 1'b0, 1'b1, FRAME_BITS);
    wait_ticks(4);
    check("t6_next_count", 32'(dv_count - base), 32'd1);
    check("t6_next_data", 32'(data), 32'h055);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
